axis_pkt_master: RTL and testbench
==================================

AXIS_PKT_MASTER -- requirements
Module: axis_pkt_master

Interface
REQ-001 Parameter DATA_W, default 8: width of m_axis_tdata in bits.
REQ-002 Parameter LEN_W, default 8: width of cfg_len; a packet is cfg_len+1 beats (1..2^LEN_W).
REQ-003 Parameter CNT_W, default 8: width of cfg_npkts, cfg_gap and pkt_sent.
REQ-004 Aclk  input  1  sole clock; all logic on rising edge.
REQ-005 Areset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a burst; ignored while busy=1.
REQ-007 cfg_len  input  LEN_W  beats per packet minus one; sampled when start is accepted.
REQ-008 cfg_npkts  input  CNT_W  packets per burst minus one; sampled when start is accepted.
REQ-009 cfg_gap  input  CNT_W  idle cycles between packets; sampled when start is accepted.
REQ-010 cfg_data0  input  DATA_W  tdata of the first beat of the burst; sampled when start is accepted.
REQ-011 m_axis_tvalid  output  1  beat valid.
REQ-012 m_axis_tready  input  1  downstream (e.g. FIFO slave port) ready.
REQ-013 m_axis_tdata  output  DATA_W  beat payload.
REQ-014 m_axis_tlast  output  1  marks the final beat of each packet.
REQ-015 m_axis_tkeep  output  1  byte-valid qualifier; 1 whenever tvalid=1, else 0.
REQ-016 busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive.
REQ-017 done  output  1  one-cycle pulse when the last beat of the last packet is accepted.
REQ-018 pkt_sent  output  CNT_W  count of packets completed in the current/last burst.

Function
REQ-019 A beat transfers on a rising edge where m_axis_tvalid=1 and m_axis_tready=1.
REQ-020 Once tvalid is asserted, tvalid, tdata, tlast and tkeep SHALL hold stable until the beat transfers.
REQ-021 tvalid SHALL NOT depend combinationally on tready; all outputs are registered.
REQ-022 FSM states: IDLE, SEND, GAP.
REQ-023 IDLE: tvalid=0; start=1 latches all cfg_* and moves to SEND, with tvalid=1 on the next cycle (1-cycle latency).
REQ-024 SEND: tdata starts at cfg_data0 and increments by 1 per transferred beat, modulo 2^DATA_W, continuing across packet boundaries.
REQ-025 SEND: tlast=1 on beat index cfg_len of each packet (beat counter from 0); tlast=0 on other beats.
REQ-026 On tlast transfer: pkt_sent increments; if it was packet cfg_npkts, assert done and go to IDLE; else go to GAP if cfg_gap>0, otherwise stay in SEND with the next packet's first beat valid in the following cycle (no bubble).
REQ-027 GAP: tvalid=0 for exactly cfg_gap cycles, then return to SEND.
REQ-028 cfg_len=0: every beat has tlast=1 (single-beat packets).
REQ-029 Back-pressure (tready=0) for any duration SHALL stall without losing, duplicating or reordering beats.
REQ-030 pkt_sent SHALL clear to 0 when start is accepted and hold its final value in IDLE.
REQ-031 Changes on cfg_* while busy SHALL NOT affect the burst in progress.

Reset
REQ-032 Areset=1 SHALL force IDLE; tvalid, tlast, tkeep, busy, done = 0; tdata = 0; pkt_sent = 0; internal counters = 0.
REQ-033 Reset asserted mid-burst SHALL abort it immediately; no done pulse; tvalid=0 on the cycle after the reset edge.
REQ-034 start sampled in the same cycle as Areset=1 SHALL be ignored.

Verification
REQ-035 cfg_len=3, cfg_npkts=0, cfg_data0=8'h10, tready=1 -> 4 consecutive beats 10,11,12,13; tlast on 13; done 1 cycle; pkt_sent=1.
REQ-036 cfg_len=1, cfg_npkts=2, cfg_gap=2, cfg_data0=0, tready=1 -> beats 0,1 | 2 idle | 2,3 | 2 idle | 4,5; tlast on 1,3,5; pkt_sent=3.
REQ-037 cfg_len=4, tready toggling pseudo-randomly -> tdata 0..4 received in order, once each, stable during every stall.
REQ-038 cfg_data0=8'hFE, cfg_len=3 -> tdata FE,FF,00,01; tlast on 01.
REQ-039 Reset pulsed after 2 beats of a 10-beat packet -> tvalid=0 next cycle, no done, pkt_sent=0; new start resumes normal operation from the new cfg_data0.
REQ-040 start pulsed while busy with different cfg_* -> ignored; original burst completes unchanged.

Source files
------------

// File: rtl/axis_pkt_master_if.sv
// AXI4-Stream master-side bundle for the packet generator.
// Carries tvalid/tready/tdata/tlast/tkeep for one stream.
interface axis_pkt_master_if #(
    parameter int DATA_W = 8
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tkeep;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tkeep,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tkeep,
        output tready
    );
endinterface

// File: rtl/axis_pkt_master.sv
// Burst packet generator: emits npkts+1 packets of len+1 incrementing beats
// on an AXI4-Stream master port, with an optional idle gap between packets.
module axis_pkt_master #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 Aclk,
    input  logic                 Areset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic [CNT_W-1:0]     cfg_npkts,
    input  logic [CNT_W-1:0]     cfg_gap,
    input  logic [DATA_W-1:0]    cfg_data0,
    axis_pkt_master_if.master    m_axis,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pkt_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   npkts_q, npkts_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   gcnt_q, gcnt_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge Aclk) begin
        if (Areset) begin
            state_q <= IDLE;
            data_q  <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            npkts_q <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            pkt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            npkts_q <= npkts_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        beat_d  = beat_q;
        len_d   = len_q;
        npkts_d = npkts_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        pkt_d   = pkt_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The done cycle still reports busy, so start is refused there.
                if (start && !done_q) begin
                    state_d = SEND;
                    len_d   = cfg_len;
                    npkts_d = cfg_npkts;
                    gap_d   = cfg_gap;
                    data_d  = cfg_data0;
                    beat_d  = '0;
                    pkt_d   = '0;
                    valid_d = 1'b1;
                    last_d  = (cfg_len == '0);
                end
            end
            SEND: begin
                if (valid_q && m_axis.tready) begin
                    data_d = data_q + DATA_W'(1);
                    if (last_q) begin
                        pkt_d  = pkt_q + CNT_W'(1);
                        beat_d = '0;
                        if (pkt_q == npkts_q) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (gap_q != '0) begin
                            state_d = GAP;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            gcnt_d  = '0;
                        end else begin
                            last_d = (len_q == '0);
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                        last_d = ((beat_q + LEN_W'(1)) == len_q);
                    end
                end
            end
            GAP: begin
                if (gcnt_q == gap_q - CNT_W'(1)) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    last_d  = (len_q == '0);
                end else begin
                    gcnt_d = gcnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || done_d;
    end

    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = data_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tkeep  = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_sent      = pkt_q;

endmodule

// File: tb/tb_axis_pkt_master.sv
// Directed bench for axis_pkt_master: burst table plus reset and
// start-while-busy sequences, checked against a small beat model.
module tb_axis_pkt_master;

    logic       Aclk;
    logic       Areset;
    logic       start;
    logic [7:0] cfg_len;
    logic [7:0] cfg_npkts;
    logic [7:0] cfg_gap;
    logic [7:0] cfg_data0;
    logic       busy;
    logic       done;
    logic [7:0] pkt_sent;

    axis_pkt_master_if #(.DATA_W(8)) m_axis ();

    axis_pkt_master #(
        .DATA_W(8),
        .LEN_W (8),
        .CNT_W (8)
    ) dut (
        .Aclk     (Aclk),
        .Areset   (Areset),
        .start    (start),
        .cfg_len  (cfg_len),
        .cfg_npkts(cfg_npkts),
        .cfg_gap  (cfg_gap),
        .cfg_data0(cfg_data0),
        .m_axis   (m_axis),
        .busy     (busy),
        .done     (done),
        .pkt_sent (pkt_sent)
    );

    initial Aclk = 1'b0;
    always #5 Aclk = ~Aclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int  len;
        int  npkts;
        int  gap;
        int  data0;
        bit  rnd;
        bit  poke;
        int  exp_beats;
        int  exp_last;
        int  exp_pkts;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Aclk);
        #1;
    endtask

    task automatic run_burst(input vec_t v, input string nm);
        int   beats = 0;
        int   beat_idx = 0;
        int   pkts = 0;
        int   idle_cnt = 0;
        int   last_data = -1;
        logic [7:0] exp_data;
        bit   in_gap = 0;
        bit   exp_done = 0;
        bit   stall = 0;
        bit   finished = 0;
        logic [7:0] s_data;
        logic s_last;
        logic rdy;

        exp_data  = 8'(v.data0);
        cfg_len   = 8'(v.len);
        cfg_npkts = 8'(v.npkts);
        cfg_gap   = 8'(v.gap);
        cfg_data0 = 8'(v.data0);
        start     = 1'b1;
        step();
        start = 1'b0;
        chk({nm, " latency tvalid"}, 32'(m_axis.tvalid), 32'd1);
        chk({nm, " busy"}, 32'(busy), 32'd1);
        chk({nm, " pkt_sent clr"}, 32'(pkt_sent), 32'd0);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (m_axis.tkeep !== m_axis.tvalid)
                chk({nm, " tkeep"}, 32'(m_axis.tkeep), 32'(m_axis.tvalid));
            if (stall) begin
                chk({nm, " stall valid"}, 32'(m_axis.tvalid), 32'd1);
                chk({nm, " stall data"}, 32'(m_axis.tdata), 32'(s_data));
                chk({nm, " stall last"}, 32'(m_axis.tlast), 32'(s_last));
                stall = 0;
            end
            if (exp_done) begin
                chk({nm, " done"}, 32'(done), 32'd1);
                chk({nm, " done busy"}, 32'(busy), 32'd1);
                chk({nm, " done tvalid"}, 32'(m_axis.tvalid), 32'd0);
                chk({nm, " pkt_sent"}, 32'(pkt_sent), 32'(v.exp_pkts));
                finished = 1;
            end else begin
                if (done)
                    chk({nm, " early done"}, 32'(done), 32'd0);
                if (in_gap) begin
                    if (m_axis.tvalid) begin
                        chk({nm, " gap len"}, 32'(idle_cnt), 32'(v.gap));
                        in_gap = 0;
                    end else begin
                        idle_cnt++;
                    end
                end
                rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                m_axis.tready = rdy;
                if (v.poke) begin
                    start     = 1'b1;
                    cfg_len   = 8'($urandom);
                    cfg_npkts = 8'($urandom);
                    cfg_gap   = 8'($urandom);
                    cfg_data0 = 8'($urandom);
                end
                if (m_axis.tvalid && rdy) begin
                    chk({nm, " tdata"}, 32'(m_axis.tdata), 32'(exp_data));
                    chk({nm, " tlast"}, 32'(m_axis.tlast),
                        32'(beat_idx == v.len));
                    last_data = int'(m_axis.tdata);
                    exp_data  = exp_data + 8'd1;
                    beats++;
                    if (beat_idx == v.len) begin
                        beat_idx = 0;
                        pkts++;
                        if (pkts == v.npkts + 1) exp_done = 1;
                        else begin
                            in_gap   = 1;
                            idle_cnt = 0;
                        end
                    end else begin
                        beat_idx++;
                    end
                end else if (m_axis.tvalid) begin
                    stall  = 1;
                    s_data = m_axis.tdata;
                    s_last = m_axis.tlast;
                end
                step();
                start = 1'b0;
            end
        end
        m_axis.tready = 1'b1;
        if (!finished) chk({nm, " timeout"}, 32'd0, 32'd1);
        chk({nm, " beats"}, 32'(beats), 32'(v.exp_beats));
        chk({nm, " last data"}, 32'(last_data), 32'(v.exp_last));
        step();
        chk({nm, " busy after"}, 32'(busy), 32'd0);
        chk({nm, " done pulse"}, 32'(done), 32'd0);
        chk({nm, " pkt_sent hold"}, 32'(pkt_sent), 32'(v.exp_pkts));
    endtask

    vec_t vecs[9];
    vec_t hv;

    initial begin
        vecs[0] = '{3, 0, 0, 8'h10, 0, 0, 4, 8'h13, 1};
        vecs[1] = '{1, 2, 2, 8'h00, 0, 0, 6, 8'h05, 3};
        vecs[2] = '{3, 0, 0, 8'hFE, 0, 0, 4, 8'h01, 1};
        vecs[3] = '{0, 3, 0, 8'h20, 0, 0, 4, 8'h23, 4};
        vecs[4] = '{2, 1, 1, 8'h7F, 0, 0, 6, 8'h84, 2};
        vecs[5] = '{4, 0, 0, 8'h00, 1, 0, 5, 8'h04, 1};
        vecs[6] = '{2, 2, 3, 8'h40, 1, 0, 9, 8'h48, 3};
        vecs[7] = '{3, 1, 0, 8'h50, 0, 1, 8, 8'h57, 2};
        vecs[8] = '{0, 0, 5, 8'hFF, 1, 1, 1, 8'hFF, 1};

        Areset        = 1'b1;
        start         = 1'b0;
        cfg_len       = '0;
        cfg_npkts     = '0;
        cfg_gap       = '0;
        cfg_data0     = '0;
        m_axis.tready = 1'b1;
        step();
        step();
        chk("rst tvalid", 32'(m_axis.tvalid), 32'd0);
        chk("rst tlast", 32'(m_axis.tlast), 32'd0);
        chk("rst tkeep", 32'(m_axis.tkeep), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst tdata", 32'(m_axis.tdata), 32'd0);
        chk("rst pkt_sent", 32'(pkt_sent), 32'd0);
        Areset = 1'b0;
        step();

        for (int i = 0; i < 9; i++)
            run_burst(vecs[i], $sformatf("vec%0d", i));

        // Reset two beats into a ten-beat packet
        cfg_len   = 8'd9;
        cfg_npkts = 8'd0;
        cfg_gap   = 8'd0;
        cfg_data0 = 8'h30;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("mid tdata0", 32'(m_axis.tdata), 32'h30);
        step();
        chk("mid tdata1", 32'(m_axis.tdata), 32'h31);
        step();
        Areset = 1'b1;
        start  = 1'b1;
        step();
        chk("mid rst tvalid", 32'(m_axis.tvalid), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst pkt_sent", 32'(pkt_sent), 32'd0);
        chk("mid rst tdata", 32'(m_axis.tdata), 32'd0);
        start = 1'b0;
        Areset = 1'b0;
        step();
        chk("rst start ign", 32'(m_axis.tvalid), 32'd0);
        chk("rst start busy", 32'(busy), 32'd0);

        hv = '{2, 0, 0, 8'h90, 0, 0, 3, 8'h92, 1};
        run_burst(hv, "resume");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
